// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: states, opcode
// classes, ALU codes and IR field positions.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_PAUSED,
        S_HALTED
    } state_t;

    typedef enum logic [3:0] {
        C_ALU3,
        C_ALUI,
        C_UNARY,
        C_MULDIV,
        C_LDI,
        C_LD,
        C_ST,
        C_NOP,
        C_HALT,
        C_ILLEGAL
    } op_class_t;

    localparam logic [4:0] ALU_INC = 5'b11111;
    localparam logic [4:0] ALU_ADD = 5'b00011;
    localparam logic [4:0] ALU_AND = 5'b00101;
    localparam logic [4:0] ALU_OR  = 5'b00110;

    localparam logic [4:0] OP_LD        = 5'b00000;
    localparam logic [4:0] OP_LDI       = 5'b00001;
    localparam logic [4:0] OP_ST        = 5'b00010;
    localparam logic [4:0] OP_ALU3_LO   = 5'b00011;
    localparam logic [4:0] OP_ALU3_HI   = 5'b01011;
    localparam logic [4:0] OP_ADDI      = 5'b01100;
    localparam logic [4:0] OP_ANDI      = 5'b01101;
    localparam logic [4:0] OP_ORI       = 5'b01110;
    localparam logic [4:0] OP_DIV       = 5'b01111;
    localparam logic [4:0] OP_MUL       = 5'b10000;
    localparam logic [4:0] OP_NEG       = 5'b10001;
    localparam logic [4:0] OP_NOT       = 5'b10010;
    localparam logic [4:0] OP_NOP       = 5'b11010;
    localparam logic [4:0] OP_HALT      = 5'b11011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int RA_MSB  = 26;
    localparam int RA_LSB  = 23;
    localparam int RB_MSB  = 22;
    localparam int RB_LSB  = 19;
    localparam int RC_MSB  = 18;
    localparam int RC_LSB  = 15;
    localparam int C_MSB   = 18;

    function automatic op_class_t decode_class(input logic [4:0] op);
        op_class_t cls;
        if (op >= OP_ALU3_LO && op <= OP_ALU3_HI) begin
            cls = C_ALU3;
        end else begin
            case (op)
                OP_LD:                   cls = C_LD;
                OP_LDI:                  cls = C_LDI;
                OP_ST:                   cls = C_ST;
                OP_ADDI, OP_ANDI, OP_ORI: cls = C_ALUI;
                OP_DIV, OP_MUL:          cls = C_MULDIV;
                OP_NEG, OP_NOT:          cls = C_UNARY;
                OP_NOP:                  cls = C_NOP;
                OP_HALT:                 cls = C_HALT;
                default:                 cls = C_ILLEGAL;
            endcase
        end
        return cls;
    endfunction

    // Immediate forms reuse the ALU codes of their register-register twins.
    function automatic logic [4:0] alui_code(input logic [4:0] op);
        logic [4:0] code;
        case (op)
            OP_ANDI: code = ALU_AND;
            OP_ORI:  code = ALU_OR;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer (master) and the datapath/memory
// side (slave): IR and handshake inputs, all strobes and ALU controls out.
interface control_sequencer_if;

    logic [31:0] ir;
    logic        mem_ready;
    logic        stop;

    logic [15:0] rin;
    logic [15:0] rout;
    logic        pc_in;
    logic        pc_out;
    logic        ir_in;
    logic        y_in;
    logic        z_in;
    logic        hi_in;
    logic        lo_in;
    logic        mar_in;
    logic        mdr_in;
    logic        mdr_out;
    logic        z_high_out;
    logic        z_low_out;
    logic        hi_out;
    logic        lo_out;
    logic        in_port_out;
    logic        c_out;
    logic        read;
    logic        write;
    logic [4:0]  alu_op;
    logic [31:0] c_value;
    logic        run;
    logic        illegal;

    modport master (
        input  ir, mem_ready, stop,
        output rin, rout, pc_in, pc_out, ir_in, y_in, z_in, hi_in, lo_in,
               mar_in, mdr_in, mdr_out, z_high_out, z_low_out, hi_out, lo_out,
               in_port_out, c_out, read, write, alu_op, c_value, run, illegal
    );

    modport slave (
        output ir, mem_ready, stop,
        input  rin, rout, pc_in, pc_out, ir_in, y_in, z_in, hi_in, lo_in,
               mar_in, mdr_in, mdr_out, z_high_out, z_low_out, hi_out, lo_out,
               in_port_out, c_out, read, write, alu_op, c_value, run, illegal
    );

endinterface

// File: rtl/reg_sel_decode.sv
// Maps a 4-bit register field to a 16-bit one-hot strobe, all zero when
// disabled.
module reg_sel_decode (
    input  logic [3:0]  sel,
    input  logic        en,
    output logic [15:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: steps each instruction through fetch T0-T2 and
// execute T3-T7, decoding all datapath strobes from the state and IR.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RESET    | held by clear; leaves on first edge after release
// T0       | PC to MAR, Z = PC + 1
// T1       | PC <= Z, memory read into MDR, waits for mem_ready
// T2       | MDR to IR
// T3..T7   | execute steps, meaning depends on opcode class
// PAUSED   | stop seen at an instruction boundary, waits for stop=0
// HALTED   | halt executed, exits only by clear
module control_sequencer (
    input  logic                clock,
    input  logic                clear,
    control_sequencer_if.master bus
);

    import cpu_ctrl_pkg::*;

    state_t     state;
    state_t     after_instr;
    op_class_t  op_class;
    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;

    logic       rin_en;
    logic [3:0] rin_sel;
    logic       rout_en;
    logic [3:0] rout_sel;

    assign opcode   = bus.ir[OPC_MSB:OPC_LSB];
    assign ra       = bus.ir[RA_MSB:RA_LSB];
    assign rb       = bus.ir[RB_MSB:RB_LSB];
    assign rc       = bus.ir[RC_MSB:RC_LSB];
    assign op_class = decode_class(opcode);

    assign after_instr = bus.stop ? S_PAUSED : S_T0;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state <= S_RESET;
        end else begin
            case (state)
                S_RESET:  state <= after_instr;
                S_T0:     state <= S_T1;
                S_T1:     if (bus.mem_ready) state <= S_T2;
                S_T2:     state <= S_T3;
                S_T3: begin
                    case (op_class)
                        C_NOP, C_ILLEGAL: state <= after_instr;
                        C_HALT:           state <= S_HALTED;
                        default:          state <= S_T4;
                    endcase
                end
                S_T4: begin
                    if (op_class == C_UNARY) state <= after_instr;
                    else                     state <= S_T5;
                end
                S_T5: begin
                    case (op_class)
                        C_ALU3, C_ALUI, C_LDI: state <= after_instr;
                        C_MULDIV, C_LD, C_ST:  state <= S_T6;
                        default:               state <= S_T0;
                    endcase
                end
                S_T6: begin
                    case (op_class)
                        C_MULDIV: state <= after_instr;
                        C_LD:     if (bus.mem_ready) state <= S_T7;
                        C_ST:     state <= S_T7;
                        default:  state <= S_T0;
                    endcase
                end
                S_T7: begin
                    case (op_class)
                        C_LD:    state <= after_instr;
                        C_ST:    if (bus.mem_ready) state <= after_instr;
                        default: state <= S_T0;
                    endcase
                end
                S_PAUSED: if (!bus.stop) state <= S_T0;
                S_HALTED: state <= S_HALTED;
                default:  state <= S_RESET;
            endcase
        end
    end

    // Strobes are a pure decode of the state register so clear removes
    // Read/Write immediately, without waiting for an edge.
    always_comb begin
        rin_en         = 1'b0;
        rin_sel        = ra;
        rout_en        = 1'b0;
        rout_sel       = rb;
        bus.pc_in      = 1'b0;
        bus.pc_out     = 1'b0;
        bus.ir_in      = 1'b0;
        bus.y_in       = 1'b0;
        bus.z_in       = 1'b0;
        bus.hi_in      = 1'b0;
        bus.lo_in      = 1'b0;
        bus.mar_in     = 1'b0;
        bus.mdr_in     = 1'b0;
        bus.mdr_out    = 1'b0;
        bus.z_high_out = 1'b0;
        bus.z_low_out  = 1'b0;
        bus.c_out      = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.alu_op     = 5'b00000;
        bus.run        = 1'b1;
        bus.illegal    = 1'b0;

        case (state)
            S_T0: begin
                bus.pc_out = 1'b1;
                bus.mar_in = 1'b1;
                bus.z_in   = 1'b1;
                bus.alu_op = ALU_INC;
            end
            S_T1: begin
                bus.z_low_out = 1'b1;
                bus.pc_in     = 1'b1;
                bus.read      = 1'b1;
                bus.mdr_in    = 1'b1;
            end
            S_T2: begin
                bus.mdr_out = 1'b1;
                bus.ir_in   = 1'b1;
            end
            S_T3: begin
                case (op_class)
                    C_ALU3, C_ALUI, C_LDI, C_LD, C_ST: begin
                        rout_en  = 1'b1;
                        bus.y_in = 1'b1;
                    end
                    C_UNARY: begin
                        rout_en    = 1'b1;
                        bus.z_in   = 1'b1;
                        bus.alu_op = opcode;
                    end
                    C_MULDIV: begin
                        rout_en  = 1'b1;
                        rout_sel = ra;
                        bus.y_in = 1'b1;
                    end
                    C_ILLEGAL: bus.illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T4: begin
                case (op_class)
                    C_ALU3: begin
                        rout_en    = 1'b1;
                        rout_sel   = rc;
                        bus.z_in   = 1'b1;
                        bus.alu_op = opcode;
                    end
                    C_ALUI: begin
                        bus.c_out  = 1'b1;
                        bus.z_in   = 1'b1;
                        bus.alu_op = alui_code(opcode);
                    end
                    C_LDI, C_LD, C_ST: begin
                        bus.c_out  = 1'b1;
                        bus.z_in   = 1'b1;
                        bus.alu_op = ALU_ADD;
                    end
                    C_UNARY: begin
                        bus.z_low_out = 1'b1;
                        rin_en        = 1'b1;
                    end
                    C_MULDIV: begin
                        rout_en    = 1'b1;
                        bus.z_in   = 1'b1;
                        bus.alu_op = opcode;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (op_class)
                    C_ALU3, C_ALUI, C_LDI: begin
                        bus.z_low_out = 1'b1;
                        rin_en        = 1'b1;
                    end
                    C_LD, C_ST: begin
                        bus.z_low_out = 1'b1;
                        bus.mar_in    = 1'b1;
                    end
                    C_MULDIV: begin
                        bus.z_low_out = 1'b1;
                        bus.lo_in     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (op_class)
                    C_MULDIV: begin
                        bus.z_high_out = 1'b1;
                        bus.hi_in      = 1'b1;
                    end
                    C_LD: begin
                        bus.read   = 1'b1;
                        bus.mdr_in = 1'b1;
                    end
                    C_ST: begin
                        rout_en    = 1'b1;
                        rout_sel   = ra;
                        bus.mdr_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (op_class)
                    C_LD: begin
                        bus.mdr_out = 1'b1;
                        rin_en      = 1'b1;
                    end
                    C_ST: bus.write = 1'b1;
                    default: ;
                endcase
            end
            default: bus.run = 1'b0;
        endcase
    end

    assign bus.hi_out      = 1'b0;
    assign bus.lo_out      = 1'b0;
    assign bus.in_port_out = 1'b0;
    assign bus.c_value     = {{(31 - C_MSB){bus.ir[C_MSB]}}, bus.ir[C_MSB:0]};

    reg_sel_decode u_rin_decode (
        .sel    (rin_sel),
        .en     (rin_en),
        .onehot (bus.rin)
    );

    reg_sel_decode u_rout_decode (
        .sel    (rout_sel),
        .en     (rout_en),
        .onehot (bus.rout)
    );

endmodule
